// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Frame field widths, sync marker default and FSM state encoding.
package loader_pkg;

  localparam int LEN_W = 16;
  localparam int CHK_W = 8;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Byte-to-word assembler: little-endian shift register, byte counter
// and running XOR over length and data bytes.
module loader_word_asm
  import loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             len_en,
  input  logic             data_en,
  input  logic [7:0]       data,
  output logic [31:0]      word_full,
  output logic             word_last,
  output logic [CHK_W-1:0] chk
);

  logic [1:0]  cnt;
  logic [31:0] word;

  // Word as it will look once the current byte lands in its lane.
  always_comb begin
    word_full = word;
    word_full[{cnt, 3'b000} +: 8] = data;
    word_last = data_en && (cnt == 2'd3);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= 2'd0;
      word <= 32'd0;
      chk  <= '0;
    end else if (clear) begin
      cnt  <= 2'd0;
      word <= 32'd0;
      chk  <= '0;
    end else begin
      if (len_en || data_en) begin
        chk <= chk ^ data;
      end
      if (data_en) begin
        cnt <= cnt + 2'd1;
        word[{cnt, 3'b000} +: 8] <= data;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing 32-bit words into instruction
// memory and holding the core in reset until the checksum verifies.
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024,
  parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] tb_addr,
  output logic [31:0] tb_inst,
  output logic        tb_we,
  output logic        cpu_reset_n,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t             state;
  logic [7:0]         len_lo;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_full;
  logic [LEN_W-1:0]   word_idx;
  logic               acc;
  logic               is_sync;
  logic               restart;
  logic               len_en;
  logic               data_en;
  logic [31:0]        word_full;
  logic               word_last;
  logic [CHK_W-1:0]   chk;

  assign acc      = rx_valid && rx_ready;
  assign is_sync  = (rx_data == SYNC_BYTE);
  assign len_full = {rx_data, len_lo};
  assign len_en   = acc && (state == S_LEN0 || state == S_LEN1);
  assign data_en  = acc && (state == S_DATA);
  assign restart  = acc && is_sync &&
                    (state == S_IDLE || state == S_DONE ||
                     state == S_ERR);

  loader_word_asm u_asm (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (restart),
    .len_en    (len_en),
    .data_en   (data_en),
    .data      (rx_data),
    .word_full (word_full),
    .word_last (word_last),
    .chk       (chk)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      rx_ready    <= 1'b0;
      tb_addr     <= BASE_ADDR;
      tb_inst     <= 32'd0;
      tb_we       <= 1'b0;
      cpu_reset_n <= 1'b0;
      load_busy   <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      len_lo      <= 8'd0;
      len         <= '0;
      word_idx    <= '0;
    end else begin
      rx_ready <= 1'b1;
      tb_we    <= 1'b0;
      if (acc) begin
        unique case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (is_sync) begin
              state       <= S_LEN0;
              cpu_reset_n <= 1'b0;
              load_done   <= 1'b0;
              load_err    <= 1'b0;
              load_busy   <= 1'b1;
            end
          end
          S_LEN0: begin
            len_lo <= rx_data;
            state  <= S_LEN1;
          end
          S_LEN1: begin
            len      <= len_full;
            word_idx <= '0;
            if ({16'd0, len_full} > MAX_W) begin
              state     <= S_ERR;
              load_busy <= 1'b0;
              load_err  <= 1'b1;
            end else if (len_full == '0) begin
              state <= S_CHK;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            if (word_last) begin
              tb_we    <= 1'b1;
              tb_inst  <= word_full;
              tb_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
              word_idx <= word_idx + 16'd1;
              if (word_idx == len - 16'd1) begin
                state <= S_CHK;
              end
            end
          end
          S_CHK: begin
            load_busy <= 1'b0;
            if (rx_data == chk) begin
              state       <= S_DONE;
              cpu_reset_n <= 1'b1;
              load_done   <= 1'b1;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame stimulus checked against a frame-level model of
// the expected memory writes, flags and checksum.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] tb_addr;
  logic [31:0] tb_inst;
  logic        tb_we;
  logic        cpu_reset_n;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  imem_loader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tb_addr     (tb_addr),
    .tb_inst     (tb_inst),
    .tb_we       (tb_we),
    .cpu_reset_n (cpu_reset_n),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] fr_words[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          last_we = 0;
  bit          have_last = 0;
  bit          gap_mode = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_total++;
    if (act !== req)
      $display("FAIL %s: got %h expected %h", name, act, req);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      check("cpu_rst_vs_done", {31'd0, cpu_reset_n}, {31'd0, load_done});
      if (tb_we) begin
        check("we_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("we_addr", tb_addr, e.a);
          check("we_inst", tb_inst, e.d);
          if (have_last) begin
            if (gap_mode)
              check("we_gap8", {31'd0, (cyc - last_we) >= 8}, 32'd1);
            else
              check("we_rate4", cyc - last_we, 32'd4);
          end
          last_we   = cyc;
          have_last = 1;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one frame built from fr_words; bad corrupts the checksum.
  task automatic run_frame(input int len, input bit bad, input bit gap,
                           output logic [7:0] c);
    bit ok;
    bit good;
    c = 8'(len) ^ 8'(len >> 8);
    for (int i = 0; i < len && i < fr_words.size(); i++)
      for (int k = 0; k < 4; k++)
        c ^= fr_words[i][8*k +: 8];
    ok   = (len <= MAXW);
    good = ok && !bad;
    if (ok)
      for (int i = 0; i < len; i++)
        exp_q.push_back('{a: BASE + 32'(4 * i), d: fr_words[i]});
    gap_mode  = gap;
    have_last = 0;
    check("rx_ready", {31'd0, rx_ready}, 32'd1);
    send_byte(8'hA5, gap);
    check("busy_after_sync", {31'd0, load_busy}, 32'd1);
    check("flags_cleared", {30'd0, load_done, load_err}, 32'd0);
    send_byte(8'(len), gap);
    send_byte(8'(len >> 8), gap);
    if (ok) begin
      for (int i = 0; i < len; i++)
        for (int k = 0; k < 4; k++)
          send_byte(fr_words[i][8*k +: 8], gap);
      send_byte(bad ? (c ^ 8'h11) : c, gap);
    end
    @(negedge clk);
    #1;
    check("load_done", {31'd0, load_done}, {31'd0, good});
    check("load_err", {31'd0, load_err}, {31'd0, !good});
    check("cpu_reset_n", {31'd0, cpu_reset_n}, {31'd0, good});
    check("busy_idle", {31'd0, load_busy}, 32'd0);
    check("writes_left", exp_q.size(), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_addr", tb_addr, BASE);
    check("rst_inst", tb_inst, 32'd0);
    check("rst_we", {31'd0, tb_we}, 32'd0);
    check("rst_flags",
          {28'd0, cpu_reset_n, load_busy, load_done, load_err}, 32'd0);
  endtask

  logic [7:0] c;
  logic [7:0] jb;

  initial begin
    #1;
    check_reset_vals();
    #11;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    fr_words = {32'h0000_0013, 32'h0010_0093};
    run_frame(2, 0, 0, c);
    check("lit_chk", {24'd0, c}, 32'h92);
    check("lit_addr", tb_addr, 32'h4);
    check("lit_inst", tb_inst, 32'h0010_0093);

    run_frame(2, 1, 0, c);
    check("lit_bad_rst", {31'd0, cpu_reset_n}, 32'd0);
    run_frame(2, 0, 0, c);

    run_frame(16'h0401, 0, 0, c);

    fr_words = {};
    run_frame(0, 0, 0, c);
    check("len0_chk", {24'd0, c}, 32'h00);

    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    fr_words = {32'h0000_0013, 32'h0010_0093};
    run_frame(2, 0, 0, c);

    run_frame(2, 0, 1, c);

    // Abandon a frame after five data bytes with an async reset.
    exp_q.push_back('{a: BASE, d: 32'h0000_0013});
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++)
      send_byte(fr_words[0][8*k +: 8], 0);
    send_byte(8'h93, 0);
    check("pre_rst_busy", {31'd0, load_busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(2, 0, 0, c);

    for (int f = 0; f < 20; f++) begin
      int n;
      n = 1 + int'($urandom_range(0, 7));
      fr_words = {};
      for (int i = 0; i < n; i++)
        fr_words.push_back($urandom);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h00;
        send_byte(jb, 0);
      end
      run_frame(n, ($urandom % 4) == 0, $urandom % 2, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
